ctta_operand_loader: RTL

Sequential operand front-end for the CTTA add/subtract stage. Captures three 4-bit operands (A, B, C) one at a time from a shared switch bus on successive load-button presses, then latches the operation select and raises `valid`. Its outputs drive the CTTA inputs directly: `ctrl=0` selects A+B, `ctrl=1` selects A−C. CTTA's combinational result is meaningful only while `valid=1`.

---
 rtl/ctta_pkg.sv | 13 +
 rtl/ctta_debounce.sv | 33 +++
 rtl/ctta_operand_loader.sv | 95 +++++++++
 3 files changed

// File: rtl/ctta_pkg.sv
// Shared definitions for the CTTA datapath and its operand loader.
package ctta_pkg;

  localparam int CTTA_DW = 4;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_C    = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/ctta_debounce.sv
// Button debouncer: out follows in only after in has held a new level for
// DB_CYCLES consecutive clocks. Used by ctta_operand_loader under CTTA_LOADER_DEBOUNCE_EN.
module ctta_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] cnt;

  // The counter restarts whenever the input agrees with the current output,
  // so any glitch shorter than the window is forgotten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      out <= 1'b1;
    end else if (in == out) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      out <= in;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ctta_operand_loader.sv
// Sequential A/B/C operand capture front-end for the CTTA add/subtract stage.
// Optional load-button debounce is compiled in with CTTA_LOADER_DEBOUNCE_EN.
module ctta_operand_loader
  import ctta_pkg::*;
#(
  parameter int DW        = CTTA_DW,
  parameter int DB_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          load_btn,
  input  logic          ctrl_in,
  input  logic          clear_btn,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic [DW-1:0] C,
  output logic          ctrl,
  output logic          valid,
  output logic [1:0]    state
);

  if (DB_CYCLES < 1) begin : g_db_check
    $error("ctta_operand_loader: DB_CYCLES must be at least 1");
  end

  logic   load_lvl;
  logic   load_q;
  logic   load_pulse;
  state_t state_q;

`ifdef CTTA_LOADER_DEBOUNCE_EN
  ctta_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_debounce (
    .clk (clk),
    .rst (rst),
    .in  (load_btn),
    .out (load_lvl)
  );
`else
  assign load_lvl = load_btn;
`endif

  // load_q resets high so a button held through reset gives no pulse.
  assign load_pulse = load_lvl & ~load_q;
  assign state      = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_A;
      A       <= '0;
      B       <= '0;
      C       <= '0;
      ctrl    <= 1'b0;
      valid   <= 1'b0;
      load_q  <= 1'b1;
    end else begin
      load_q <= load_lvl;
      if (clear_btn) begin
        state_q <= S_A;
        A       <= '0;
        B       <= '0;
        C       <= '0;
        ctrl    <= 1'b0;
        valid   <= 1'b0;
      end else if (load_pulse) begin
        unique case (state_q)
          S_A: begin
            A       <= din;
            state_q <= S_B;
          end
          S_B: begin
            B       <= din;
            state_q <= S_C;
          end
          S_C: begin
            C       <= din;
            ctrl    <= ctrl_in;
            valid   <= 1'b1;
            state_q <= S_DONE;
          end
          S_DONE: begin
            // Restart the sequence: old B/C/ctrl stay but are no longer valid.
            A       <= din;
            valid   <= 1'b0;
            state_q <= S_B;
          end
          default: state_q <= S_A;
        endcase
      end
    end
  end

endmodule
